// File: rtl/univ_shift_reg.sv
// Universal shift register / register bank.
// Holds a WIDTH-bit word that updates on the edge selected by NEG_EDGE.
// Capture priority: clr > set > (ce & mode) > hold. reset is asynchronous.
// qbar, so_msb and so_lsb are plain combinational taps of q.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter bit               NEG_EDGE  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             clr,
    input  logic             set,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si_l,
    input  logic             si_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             so_msb,
    output logic             so_lsb
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_ASHR = 3'b110;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state selection; the reserved mode and mode 000 both hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = RESET_VAL;
        end else if (set) begin
            q_d = SET_VAL;
        end else if (ce) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = d;
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], si_l};
                MODE_SHR:  q_d = {si_r, q_q[WIDTH-1:1]};
                MODE_ROTL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROTR: q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ASHR: q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                default:   q_d = q_q;
            endcase
        end
    end

    // State register on the configured capture edge, async reset to RESET_VAL.
    generate
        if (NEG_EDGE) begin : g_neg_edge
            always_ff @(negedge clk or posedge reset) begin
                if (reset) q_q <= RESET_VAL;
                else       q_q <= q_d;
            end
        end else begin : g_pos_edge
            always_ff @(posedge clk or posedge reset) begin
                if (reset) q_q <= RESET_VAL;
                else       q_q <= q_d;
            end
        end
    endgenerate

    // Output taps, no extra register stage.
    always_comb begin
        q      = q_q;
        qbar   = ~q_q;
        so_msb = q_q[WIDTH-1];
        so_lsb = q_q[0];
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       clr = 1'b0;
    logic       set = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] d = 8'h00;
    logic       si_l = 1'b0;
    logic       si_r = 1'b0;

    logic [7:0] qn, qbarn, qp, qbarp;
    logic       so_msb_n, so_lsb_n, so_msb_p, so_lsb_p;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .NEG_EDGE(1'b1)) dut_n (
        .clk(clk), .reset(reset), .ce(ce), .clr(clr), .set(set), .mode(mode),
        .d(d), .si_l(si_l), .si_r(si_r),
        .q(qn), .qbar(qbarn), .so_msb(so_msb_n), .so_lsb(so_lsb_n)
    );

    univ_shift_reg #(.WIDTH(8), .NEG_EDGE(1'b0)) dut_p (
        .clk(clk), .reset(reset), .ce(ce), .clr(clr), .set(set), .mode(mode),
        .d(d), .si_l(si_l), .si_r(si_r),
        .q(qp), .qbar(qbarp), .so_msb(so_msb_p), .so_lsb(so_lsb_p)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_n(input string nm, input logic [7:0] exp);
        chk({nm, ".q"}, qn, exp);
        chk({nm, ".qbar"}, qbarn, ~exp);
        chk({nm, ".so_msb"}, {7'd0, so_msb_n}, {7'd0, exp[7]});
        chk({nm, ".so_lsb"}, {7'd0, so_lsb_n}, {7'd0, exp[0]});
    endtask

    // Monitor: after each falling edge the negedge DUT presents a new word.
    always @(negedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            chk_n(it.name, it.exp);
        end
    end

    // Caller sets inputs at posedge+1; expectation is for the coming falling edge.
    task automatic step(input string nm, input logic [7:0] exp);
        sb_item_t it;
        it.name = nm;
        it.exp  = exp;
        sb_q.push_back(it);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic load(input string nm, input logic [7:0] v);
        ce = 1'b1; clr = 1'b0; set = 1'b0; mode = 3'b001; d = v;
        step(nm, v);
    endtask

    function automatic logic [7:0] model_next(
        input logic [7:0] cur, input logic rst_i, input logic ce_i, input logic clr_i,
        input logic set_i, input logic [2:0] m, input logic [7:0] din,
        input logic sl, input logic sr);
        logic [7:0] r;
        r = cur;
        if (rst_i)       r = 8'h00;
        else if (clr_i)  r = 8'h00;
        else if (set_i)  r = 8'hFF;
        else if (ce_i) begin
            if (m == 3'd1)      r = din;
            else if (m == 3'd2) r = (cur << 1) | {7'd0, sl};
            else if (m == 3'd3) r = (cur >> 1) | {sr, 7'd0};
            else if (m == 3'd4) r = (cur << 1) | (cur >> 7);
            else if (m == 3'd5) r = (cur >> 1) | (cur << 7);
            else if (m == 3'd6) r = (cur >> 1) | (cur & 8'h80);
        end
        return r;
    endfunction

    initial begin
        logic [7:0] rotl_exp [8];
        logic [7:0] ser_exp [8];
        logic [7:0] model;
        int         wait_cnt;

        rotl_exp = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        ser_exp  = '{8'h68, 8'hD0, 8'hA0, 8'h40, 8'h80, 8'h00, 8'h00, 8'h00};

        // Power-up reset
        #2;
        chk_n("reset_init", 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: async reset mid-cycle
        load("load_a5", 8'hA5);
        #2;
        reset = 1'b1;
        #1;
        chk_n("async_reset", 8'h00);
        step("reset_held", 8'h00);
        reset = 1'b0;
        load("load_3c_after_reset", 8'h3C);

        // 2: shifts and rotates
        load("load_81", 8'h81);
        mode = 3'b010; si_l = 1'b1;
        step("shl", 8'h03);
        mode = 3'b011; si_r = 1'b0;
        step("shr", 8'h01);
        mode = 3'b011; si_r = 1'b1;
        step("shr_si1", 8'h80);
        load("load_81b", 8'h81);
        mode = 3'b100;
        for (int i = 0; i < 8; i++) step($sformatf("rotl%0d", i), rotl_exp[i]);
        mode = 3'b101;
        step("rotr", 8'hC0);
        mode = 3'b111;
        step("reserved_hold", 8'hC0);
        mode = 3'b000;
        step("mode_hold", 8'hC0);
        load("load_80", 8'h80);
        mode = 3'b110;
        step("ashr", 8'hC0);
        load("load_40", 8'h40);
        mode = 3'b110;
        step("ashr_pos", 8'h20);

        // 3: clock enable, clr/set priority
        load("load_5a", 8'h5A);
        ce = 1'b0; mode = 3'b001; d = 8'hFF;
        for (int i = 0; i < 3; i++) step($sformatf("ce0_hold%0d", i), 8'h5A);
        set = 1'b1;
        step("set_ce0", 8'hFF);
        clr = 1'b1;
        step("clr_and_set", 8'h00);
        set = 1'b0;
        load("load_f0", 8'hF0);
        ce = 1'b0; clr = 1'b1;
        step("clr_ce0", 8'h00);
        clr = 1'b0;

        // 4: edge selection, d differs at rising and falling edges
        ce = 1'b1; mode = 3'b001; d = 8'h11;
        begin
            sb_item_t it;
            it.name = "edge_pre";
            it.exp  = 8'h11;
            sb_q.push_back(it);
        end
        @(negedge clk);
        #1;
        d = 8'h22;
        @(posedge clk);
        #1;
        d = 8'h33;
        chk("edge_pos_dut", qp, 8'h22);
        chk("edge_pos_qbar", qbarp, 8'hDD);
        step("edge_neg_dut", 8'h33);

        // 5: serialise B4 through so_msb
        load("ser_load", 8'hB4);
        mode = 3'b010; si_l = 1'b0;
        for (int i = 0; i < 8; i++) step($sformatf("ser%0d", i), ser_exp[i]);

        // 6: random operations vs reference model
        model = qn;
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(63) == 0);
            ce    = $urandom_range(1);
            clr   = ($urandom_range(15) == 0);
            set   = ($urandom_range(15) == 0);
            mode  = 3'($urandom_range(7));
            d     = 8'($urandom);
            si_l  = $urandom_range(1);
            si_r  = $urandom_range(1);
            model = model_next(model, reset, ce, clr, set, mode, d, si_l, si_r);
            step("rand", model);
        end
        reset = 1'b0;

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
